// File: rtl/event_link_pkg.sv
// Shared definitions for the event-timestamp serial link: field widths,
// frame length, receiver state encoding and the frame parity rule.
package event_link_pkg;

  localparam int DEF_CH_W   = 2;
  localparam int DEF_TS_W   = 16;
  localparam int FRAME_BITS = DEF_CH_W + DEF_TS_W + 4;

  // Widest payload the parity helper accepts; narrower payloads are zero-extended.
  localparam int PAR_MAX_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Even parity bit for a payload: makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/event_rx_sampler.sv
// Line front end: 2-flop synchronizer, falling-edge detect and the bit-period
// counter that produces one sample strobe per serial bit.
module event_rx_sampler
  import event_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  input  logic i_run,
  input  logic i_half,
  output logic o_fall,
  output logic o_sample_stb,
  output logic o_bit
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_sync;
  logic                   w_stb;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign w_sync_d[gi] = serial_in;
      end else begin : g_chain
        assign w_sync_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer and edge-detect history reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= w_sync_d;
      r_prev <= w_sync;
    end
  end

  // Start bit is sampled half a bit in, every later bit one full period after.
  assign w_stb = i_run && (r_cnt == (i_half ? HALF_CNT : FULL_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || w_stb) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_fall       = r_prev & ~w_sync;
  assign o_sample_stb = w_stb;
  assign o_bit        = w_sync;

endmodule

// File: rtl/event_frame_rx.sv
// Event-timestamp frame receiver: decodes start/channel/ovf/timestamp/parity/stop
// frames into records held in a single-entry valid/ready buffer.
module event_frame_rx
  import event_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TS_W         = DEF_TS_W,
  parameter int CH_W         = DEF_CH_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            serial_in,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [CH_W-1:0] rec_channel,
  output logic            rec_ovf,
  output logic [TS_W-1:0] rec_timestamp,
  output logic            parity_err,
  output logic            framing_err,
  output logic            drop,
  output logic            busy
);

  localparam int DATA_W    = CH_W + 1 + TS_W;
  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_next;
  logic [DATA_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_par_bit;

  logic                  r_rec_valid;
  logic [CH_W-1:0]       r_rec_channel;
  logic                  r_rec_ovf;
  logic [TS_W-1:0]       r_rec_ts;
  logic                  r_parity_err;
  logic                  r_framing_err;
  logic                  r_drop;

  logic w_fall;
  logic w_stb;
  logic w_bit;
  logic w_run;
  logic w_half;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_par_en;
  logic w_par_ok;
  logic w_deliver;
  logic w_perr;
  logic w_ferr;
  logic w_load;

  assign w_run  = (r_state == START) || (r_state == DATA) ||
                  (r_state == PARITY) || (r_state == STOP);
  assign w_half = (r_state == START);

  event_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_sampler (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .i_run        (w_run),
    .i_half       (w_half),
    .o_fall       (w_fall),
    .o_sample_stb (w_stb),
    .o_bit        (w_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_deliver    = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    w_par_ok     = (even_parity(PAR_MAX_W'(r_shift)) == r_par_bit);
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next = START;
          w_cnt_clr    = 1'b1;
        end
      end
      START: begin
        // A line that is high again at mid-bit was only a glitch.
        if (w_stb) begin
          w_state_next = w_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_stb) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_stb) begin
          w_par_en     = 1'b1;
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_stb) begin
          if (!w_bit) begin
            w_ferr       = 1'b1;
            w_state_next = WAIT_IDLE;
          end else begin
            w_deliver    = w_par_ok;
            w_perr       = ~w_par_ok;
            w_state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_bit) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[DATA_W-2:0], w_bit};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_par_en) begin
        r_par_bit <= w_bit;
      end
    end
  end

  // A held record may be replaced only in the cycle the consumer takes it.
  assign w_load = w_deliver & (~r_rec_valid | rec_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec_valid   <= 1'b0;
      r_rec_channel <= '0;
      r_rec_ovf     <= 1'b0;
      r_rec_ts      <= '0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (w_load) begin
        r_rec_valid   <= 1'b1;
        r_rec_channel <= r_shift[DATA_W-1 -: CH_W];
        r_rec_ovf     <= r_shift[TS_W];
        r_rec_ts      <= r_shift[TS_W-1:0];
      end else if (rec_ready) begin
        r_rec_valid   <= 1'b0;
      end
      r_parity_err  <= w_perr;
      r_framing_err <= w_ferr;
      r_drop        <= w_deliver & ~w_load;
    end
  end

  assign rec_valid     = r_rec_valid;
  assign rec_channel   = r_rec_channel;
  assign rec_ovf       = r_rec_ovf;
  assign rec_timestamp = r_rec_ts;
  assign parity_err    = r_parity_err;
  assign framing_err   = r_framing_err;
  assign drop          = r_drop;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_event_frame_rx.sv
// Self-checking bench for event_frame_rx: scoreboarded frames, error frames,
// buffer-full drop, glitch rejection, mid-frame reset and back-to-back traffic.
module tb_event_frame_rx;

  localparam int CPB  = 16;
  localparam int CH_W = 2;
  localparam int TS_W = 16;
  localparam int FB   = CH_W + TS_W + 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            serial_in;
  logic            rec_ready;
  logic            rec_valid;
  logic [CH_W-1:0] rec_channel;
  logic            rec_ovf;
  logic [TS_W-1:0] rec_timestamp;
  logic            parity_err;
  logic            framing_err;
  logic            drop;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  int n_valid_cyc, n_perr, n_ferr, n_drop, busy_run, busy_max;
  logic [CH_W+TS_W:0] exp_q[$];
  logic [CH_W+TS_W:0] got_q[$];

  event_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .TS_W         (TS_W),
    .CH_W         (CH_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_in     (serial_in),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_channel   (rec_channel),
    .rec_ovf       (rec_ovf),
    .rec_timestamp (rec_timestamp),
    .parity_err    (parity_err),
    .framing_err   (framing_err),
    .drop          (drop),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: collects transferred records and pulse counts on the falling edge.
  always @(negedge clk) begin
    if (rec_valid) n_valid_cyc++;
    if (rec_valid && rec_ready) got_q.push_back({rec_channel, rec_ovf, rec_timestamp});
    if (parity_err) n_perr++;
    if (framing_err) n_ferr++;
    if (drop) n_drop++;
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  function automatic logic [FB-1:0] build_frame(input logic [CH_W-1:0] ch, input logic ovf,
                                                input logic [TS_W-1:0] ts, input logic par_flip,
                                                input logic stop_bit);
    logic par;
    par = (^{ch, ovf, ts}) ^ par_flip;
    return {1'b0, ch, ovf, ts, par, stop_bit};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bits(input logic [FB-1:0] f, input int nbits);
    for (int i = FB - 1; i >= FB - nbits; i--) begin
      serial_in = f[i];
      wait_clk(CPB);
    end
  endtask

  task automatic clear_stats();
    n_valid_cyc = 0;
    n_perr      = 0;
    n_ferr      = 0;
    n_drop      = 0;
    busy_max    = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    serial_in = 1'b1;
    rec_ready = 1'b1;
    clear_stats();
    wait_clk(3);
    @(negedge clk);
    n_checks++;
    if ({rec_valid, parity_err, framing_err, drop, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {rec_valid, parity_err, framing_err, drop, busy});
    else n_pass++;
    n_checks++;
    if ({rec_channel, rec_ovf, rec_timestamp} !== '0)
      $display("FAIL reset_record: got %h required 0", {rec_channel, rec_ovf, rec_timestamp});
    else n_pass++;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(5);
    $display("reset: released");
  endtask

  task automatic test_good_frame();
    logic [CH_W+TS_W:0] e;
    clear_stats();
    exp_q.push_back({2'd2, 1'b0, 16'hA5C3});
    send_bits(build_frame(2'd2, 1'b0, 16'hA5C3, 1'b0, 1'b1), FB);
    serial_in = 1'b1;
    wait_clk(2 * CPB);
    n_checks++;
    if (got_q.size() != 1) $display("FAIL good_count: got %0d records required 1", got_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[0] !== e) $display("FAIL good_record: got %h required %h", got_q[0], e);
      else n_pass++;
      void'(got_q.pop_front());
    end
    n_checks++;
    if (n_valid_cyc != 1) $display("FAIL good_valid_cycles: got %0d required 1", n_valid_cyc);
    else n_pass++;
    n_checks++;
    if (n_perr + n_ferr + n_drop != 0)
      $display("FAIL good_no_errors: got perr=%0d ferr=%0d drop=%0d required 0", n_perr, n_ferr, n_drop);
    else n_pass++;
    $display("good_frame: ch=2 ovf=0 ts=a5c3 valid_cycles=%0d", n_valid_cyc);
  endtask

  task automatic test_parity_err();
    clear_stats();
    send_bits(build_frame(2'd2, 1'b0, 16'hA5C3, 1'b1, 1'b1), FB);
    serial_in = 1'b1;
    wait_clk(2 * CPB);
    n_checks++;
    if (n_perr != 1) $display("FAIL parity_pulse: got %0d pulses required 1", n_perr);
    else n_pass++;
    n_checks++;
    if (n_valid_cyc != 0 || n_ferr != 0)
      $display("FAIL parity_no_record: got valid_cycles=%0d ferr=%0d required 0", n_valid_cyc, n_ferr);
    else n_pass++;
    $display("parity_err: pulses=%0d", n_perr);
  endtask

  task automatic test_framing_err();
    clear_stats();
    send_bits(build_frame(2'd1, 1'b1, 16'h1234, 1'b0, 1'b0), FB);
    wait_clk(100);
    @(negedge clk);
    n_checks++;
    if (n_ferr != 1) $display("FAIL framing_pulse: got %0d pulses required 1", n_ferr);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL framing_wait_idle: got busy=%b required 1", busy);
    else n_pass++;
    serial_in = 1'b1;
    wait_clk(5);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL framing_back_idle: got busy=%b required 0", busy);
    else n_pass++;
    wait_clk(2 * CPB);
    n_checks++;
    if (n_valid_cyc != 0 || n_perr != 0 || busy !== 1'b0)
      $display("FAIL framing_no_restart: got valid_cycles=%0d perr=%0d busy=%b required 0 0 0",
               n_valid_cyc, n_perr, busy);
    else n_pass++;
    $display("framing_err: pulses=%0d", n_ferr);
  endtask

  task automatic test_drop();
    logic [CH_W+TS_W:0] e;
    clear_stats();
    rec_ready = 1'b0;
    exp_q.push_back({2'd1, 1'b0, 16'h0001});
    send_bits(build_frame(2'd1, 1'b0, 16'h0001, 1'b0, 1'b1), FB);
    send_bits(build_frame(2'd0, 1'b1, 16'h0002, 1'b0, 1'b1), FB);
    serial_in = 1'b1;
    wait_clk(2 * CPB);
    @(negedge clk);
    n_checks++;
    if (n_drop != 1) $display("FAIL drop_pulse: got %0d pulses required 1", n_drop);
    else n_pass++;
    n_checks++;
    if (rec_valid !== 1'b1) $display("FAIL drop_held_valid: got %b required 1", rec_valid);
    else n_pass++;
    n_checks++;
    if ({rec_channel, rec_ovf, rec_timestamp} !== exp_q[0])
      $display("FAIL drop_held_record: got %h required %h", {rec_channel, rec_ovf, rec_timestamp}, exp_q[0]);
    else n_pass++;
    rec_ready = 1'b1;
    wait_clk(4);
    n_checks++;
    if (got_q.size() != 1) $display("FAIL drop_count: got %0d records required 1", got_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[0] !== e) $display("FAIL drop_record: got %h required %h", got_q[0], e);
      else n_pass++;
      void'(got_q.pop_front());
    end
    @(negedge clk);
    n_checks++;
    if (rec_valid !== 1'b0) $display("FAIL drop_drained: got valid=%b required 0", rec_valid);
    else n_pass++;
    $display("drop: pulses=%0d", n_drop);
  endtask

  task automatic test_glitch();
    clear_stats();
    serial_in = 1'b0;
    wait_clk(5);
    serial_in = 1'b1;
    wait_clk(3 * CPB);
    n_checks++;
    if ((busy_max >= 1 && busy_max <= CPB / 2 + 2) !== 1'b1)
      $display("FAIL glitch_busy_len: got %0d cycles required 1..%0d", busy_max, CPB / 2 + 2);
    else n_pass++;
    n_checks++;
    if (n_valid_cyc + n_perr + n_ferr + n_drop != 0)
      $display("FAIL glitch_quiet: got valid=%0d perr=%0d ferr=%0d drop=%0d required 0",
               n_valid_cyc, n_perr, n_ferr, n_drop);
    else n_pass++;
    $display("glitch: busy_cycles=%0d", busy_max);
  endtask

  task automatic test_reset_mid();
    logic [CH_W+TS_W:0] e;
    clear_stats();
    send_bits(build_frame(2'd0, 1'b0, 16'h5555, 1'b0, 1'b1), 7);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstmid_in_frame: got busy=%b required 1", busy);
    else n_pass++;
    rst_n     = 1'b0;
    serial_in = 1'b1;
    wait_clk(2);
    @(negedge clk);
    n_checks++;
    if ({rec_valid, parity_err, framing_err, drop, busy, rec_channel, rec_ovf, rec_timestamp} !== '0)
      $display("FAIL rstmid_outputs: got %h required 0",
               {rec_valid, parity_err, framing_err, drop, busy, rec_channel, rec_ovf, rec_timestamp});
    else n_pass++;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(5);
    exp_q.push_back({2'd3, 1'b1, 16'hFFFF});
    send_bits(build_frame(2'd3, 1'b1, 16'hFFFF, 1'b0, 1'b1), FB);
    serial_in = 1'b1;
    wait_clk(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || n_perr + n_ferr != 0)
      $display("FAIL rstmid_count: got %0d records perr=%0d ferr=%0d required 1 0 0",
               got_q.size(), n_perr, n_ferr);
    else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[0] !== e) $display("FAIL rstmid_record: got %h required %h", got_q[0], e);
      else n_pass++;
      void'(got_q.pop_front());
    end
    $display("reset_mid: frame after reset ch=3 ovf=1 ts=ffff");
  endtask

  task automatic test_back_to_back();
    logic [CH_W+TS_W:0] e;
    logic [CH_W-1:0]    ch;
    logic               ovf;
    logic [TS_W-1:0]    ts;
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      ch  = CH_W'($urandom_range(0, 3));
      ovf = 1'($urandom_range(0, 1));
      ts  = TS_W'($urandom);
      exp_q.push_back({ch, ovf, ts});
      send_bits(build_frame(ch, ovf, ts, 1'b0, 1'b1), FB);
    end
    serial_in = 1'b1;
    wait_clk(2 * CPB);
    n_checks++;
    if (got_q.size() != 4 || n_drop + n_perr + n_ferr != 0)
      $display("FAIL b2b_count: got %0d records drop=%0d perr=%0d ferr=%0d required 4 0 0 0",
               got_q.size(), n_drop, n_perr, n_ferr);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        $display("FAIL b2b_record: got none required %h", e);
      end else begin
        if (got_q[0] !== e) $display("FAIL b2b_record: got %h required %h", got_q[0], e);
        else n_pass++;
        void'(got_q.pop_front());
      end
    end
    $display("back_to_back: 4 frames sent");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_framing_err();
    test_drop();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/event_frame_rx.md
# event_frame_rx

Serial receiver for the event-timestamp link. Decodes the frame stream produced on the timestamper's `serial_out` pin back into parallel event records (channel, overflow flag, timestamp). Sits on the host/FPGA side of the link. Delivers each record through a single-entry valid/ready output buffer, with per-frame error and drop reporting.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range 4..1024, even values only.
- `TS_W`, 16: timestamp field width.
- `CH_W`, 2: channel-id field width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `serial_in`  in  1  link line; asynchronous to `clk`; idles high.
- `rec_valid`  out  1  a record is held in the output buffer.
- `rec_ready`  in  1  consumer accepts the record.
- `rec_channel`  out  CH_W  channel id of the held record.
- `rec_ovf`  out  1  overflow flag of the held record.
- `rec_timestamp`  out  TS_W  timestamp of the held record.
- `parity_err`  out  1  1-cycle pulse: a frame was discarded on bad parity.
- `framing_err`  out  1  1-cycle pulse: a frame was discarded on a bad stop bit.
- `drop`  out  1  1-cycle pulse: a good frame was lost because the buffer was full.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame, MSB first: start(0), channel[CH_W], ovf, timestamp[TS_W], parity, stop(1). Default frame is 22 bits.
- Parity is even over channel, ovf and timestamp: the total count of ones including the parity bit is even.
- `serial_in` passes through a 2-flop synchronizer; both flops reset to 1.
- State machine:
  - IDLE → START on a synchronized falling edge; the bit counter clears.
  - START: samples at count `CLKS_PER_BIT/2`. Low → DATA. High → IDLE (glitch rejected, no error pulse).
  - DATA: samples each bit `CLKS_PER_BIT` cycles after the previous sample and shifts it into a (CH_W+1+TS_W)-bit register. After the last data bit → PARITY.
  - PARITY: one sample, then → STOP.
  - STOP: samples the stop bit.
    - Stop = 1 and parity good → deliver, then IDLE.
    - Stop = 1 and parity bad → `parity_err`, then IDLE.
    - Stop = 0 → `framing_err`, then WAIT_IDLE. Framing takes precedence when both errors are present.
  - WAIT_IDLE: stays until the synchronized line is high, then → IDLE. This prevents false starts during a line break.
- Delivery:
  - If `rec_valid` is 0, or `rec_ready` is 1 in the same cycle, load the buffer and set `rec_valid`.
  - Otherwise pulse `drop` and leave the held record unchanged.
- Handshake: a transfer occurs on any cycle with `rec_valid & rec_ready`. `rec_valid` falls the next cycle unless a new record loads in the same cycle. The record fields stay stable while `rec_valid` is high.
- Reset values:
  - `rec_valid`, `parity_err`, `framing_err`, `drop`, `busy` = 0.
  - `rec_channel`, `rec_ovf`, `rec_timestamp` = 0.
  - State = IDLE.
- Reset mid-frame discards the partial frame. No error pulse is generated.

## Timing
- Synchronizer latency: 2 cycles from a `serial_in` edge to the internal edge detect.
- The start bit is sampled `CLKS_PER_BIT/2` cycles after the edge detect. Each following sample is `CLKS_PER_BIT` later. This gives ±`CLKS_PER_BIT/2 − 1` cycles of tolerance.
- `rec_valid` rises 1 cycle after the stop-bit sample. `parity_err`, `framing_err` and `drop` pulse in that same cycle.
- With a continuous consumer, a back-to-back frame whose start edge immediately follows the stop bit is received without loss. IDLE is re-entered before the next edge is detected.
- A single-cycle low glitch shorter than `CLKS_PER_BIT/2` is rejected in START.

## Structure
- Shared package `event_link_pkg`:
  - default `CH_W` and `TS_W`;
  - `FRAME_BITS` = CH_W+TS_W+4;
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - the parity function.

  The future transmitter model and scoreboard import the same package.
- One sub-module, `event_rx_sampler`: holds the 2-flop synchronizer, the falling-edge detect and the bit-period counter. It emits a `sample_stb` strobe and the synchronized bit. The FSM, shift register and output buffer stay in `event_frame_rx`.

## Test plan
Defaults apply: `CLKS_PER_BIT`=16, CH_W=2, TS_W=16.
- Good frame, ch=2, ovf=0, ts=0xA5C3, parity=1, `rec_ready` held 1 → `rec_valid` for exactly 1 cycle with channel=2, ovf=0, timestamp=0xA5C3; no error pulses.
- Same frame with the parity bit sent as 0 → `parity_err` pulses once; `rec_valid` stays 0.
- Stop bit sent 0, then the line held low for 100 cycles before idling → `framing_err` once; no new start is detected until the line returns high.
- `rec_ready`=0, two good frames (ts=0x0001, ts=0x0002) → first held with `rec_valid`=1; `drop` pulses at the second frame end; held timestamp stays 0x0001.
- 5-cycle low glitch on an idle line → no `busy` beyond START, no record, no error pulses.
- `rst_n` asserted mid-DATA, then released, then a good frame with ts=0xFFFF, ch=3, ovf=1 → all outputs 0 during reset; the later frame is received correctly.
